// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// State encodings are fixed so the register can be decoded directly.
package serial_adder_ctrl_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Counter width for a WIDTH-bit operand; WIDTH is at least 2.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell sequenced by the serial adder controller.
module serial_adder_ctrl_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: feeds one full adder cell LSB first, one bit per clock,
// with a start/done handshake and registered sum/carry-out.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_cout;

  serial_adder_ctrl_full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        acc_d   = {fa_s, acc_q[WIDTH-1:1]};
        carry_d = fa_cout;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          sum_d   = acc_d;
          cout_d  = fa_cout;
          state_d = StDone;
        end
      end
      StDone: begin
        // A start in the done cycle is accepted back-to-back.
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StShift);
    done = (state_q == StDone);
    sum  = sum_q;
    cout = cout_q;
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random self-checking bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int unsigned  n_checks = 0;
  int unsigned  n_fail = 0;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives a request sampled at the next posedge (E0) and returns at
  // the negedge where done is seen. poke>0 pulses an FF+FF request that must be ignored at E<poke>.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                        input int unsigned poke, input string tag);
    logic [8:0]  ref_v;
    int unsigned k;
    int unsigned busy_n;
    ref_v = {1'b0, ta} + {1'b0, tbv} + {8'b0, tc};
    a = ta;
    b = tbv;
    cin = tc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    busy_n = 0;
    check_eq({tag, "/done_early"}, 32'(done), 32'd0);
    while (!done && k < 20) begin
      if (busy) busy_n++;
      if (k == 4) begin
        check_eq({tag, "/sum_hold"}, 32'(sum), 32'(last_sum));
        check_eq({tag, "/cout_hold"}, 32'(cout), 32'(last_cout));
      end
      if (poke != 0 && k == poke - 1) begin
        a = 8'hFF;
        b = 8'hFF;
        cin = 1'b1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check_eq({tag, "/latency"}, k, 32'd8);
    check_eq({tag, "/busy_cycles"}, busy_n, 32'd8);
    check_eq({tag, "/busy_at_done"}, 32'(busy), 32'd0);
    check_eq({tag, "/sum"}, 32'(sum), 32'(ref_v[7:0]));
    check_eq({tag, "/cout"}, 32'(cout), 32'(ref_v[8]));
    last_sum = ref_v[7:0];
    last_cout = ref_v[8];
  endtask

  task automatic idle_after(input string tag);
    @(negedge clk);
    check_eq({tag, "/done_fall"}, 32'(done), 32'd0);
    check_eq({tag, "/idle_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "/sum_keep"}, 32'(sum), 32'(last_sum));
  endtask

  initial begin
    int unsigned n_done;
    repeat (3) @(negedge clk);
    check_eq("rst/busy", 32'(busy), 32'd0);
    check_eq("rst/done", 32'(done), 32'd0);
    check_eq("rst/sum", 32'(sum), 32'd0);
    check_eq("rst/cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h00, 8'h00, 1'b0, 0, "zero");
    idle_after("zero");
    run_op(8'hFF, 8'h01, 1'b0, 0, "ff_01");
    idle_after("ff_01");
    run_op(8'hA5, 8'h5A, 1'b1, 0, "a5_5a");
    idle_after("a5_5a");
    run_op(8'h12, 8'h34, 1'b0, 3, "ignore");
    check_eq("ignore/sum46", 32'(sum), 32'h46);
    idle_after("ignore");

    // Second request held in the done cycle; its done lands 9 edges after the first.
    run_op(8'h12, 8'h34, 1'b0, 0, "b2b_1");
    run_op(8'h80, 8'h80, 1'b0, 0, "b2b_2");
    check_eq("b2b_2/cout1", 32'(cout), 32'd1);
    idle_after("b2b_2");
    run_op(8'h12, 8'h34, 1'b0, 0, "pre_rst");
    idle_after("pre_rst");

    a = 8'hF0;
    b = 8'h0F;
    cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst/busy", 32'(busy), 32'd0);
    check_eq("mid_rst/done", 32'(done), 32'd0);
    check_eq("mid_rst/sum", 32'(sum), 32'd0);
    check_eq("mid_rst/cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_eq("mid_rst/no_done", n_done, 32'd0);
    last_sum = '0;
    last_cout = 1'b0;
    run_op(8'h3C, 8'h4B, 1'b1, 0, "post_rst");
    idle_after("post_rst");

    for (int i = 0; i < 1000; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 0, "rand");
      if ($urandom_range(1, 0) == 1) idle_after("rand");
    end
    idle_after("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
